// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - ball sequencer: erase, bounce, step, redraw, serve and lives
module ball_ctrl #(
  parameter int XMAX     = 159,
  parameter int YMAX     = 119,
  parameter int PADDLE_Y = 112,
  parameter int PADDLE_W = 16,
  parameter int LIVES    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       launch,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] paddle_x,
  input  logic       brick_hit,
  input  logic       draw_ack,
  output logic       ball_en,
  output logic       x_du,
  output logic       y_du,
  output logic       ball_rst_n,
  output logic       draw_req,
  output logic       draw_erase,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       tick_overrun
);

  localparam logic [7:0] XMAX_C   = 8'(XMAX);
  localparam logic [6:0] YMAX_C   = 7'(YMAX);
  localparam logic [6:0] BOUNCE_Y = 7'(PADDLE_Y - 1);
  localparam logic [8:0] PAD_SPAN = 9'(PADDLE_W - 1);
  localparam logic [1:0] LIVES_C  = 2'(LIVES);

  typedef enum logic [2:0] {
    S_SERVE,
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_STEP,
    S_DRAW,
    S_LOST,
    S_OVER
  } state_t;

  state_t     state_q, state_d;
  logic       x_du_q, x_du_d;
  logic       y_du_q, y_du_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_rst_n_q, ball_rst_n_d;
  logic       draw_req_q, draw_req_d;
  logic       draw_erase_q, draw_erase_d;
  logic [1:0] lives_q, lives_d;
  logic       game_over_q, game_over_d;
  logic       tick_overrun_q, tick_overrun_d;

  logic [8:0] pad_lo;
  logic [8:0] pad_hi;
  logic [8:0] bx9;
  logic       on_paddle;
  logic [1:0] lives_dec;

  // Paddle window compare done in 9 bits so a paddle near the right edge cannot wrap
  always_comb begin
    pad_lo    = {1'b0, paddle_x};
    pad_hi    = pad_lo + PAD_SPAN;
    bx9       = {1'b0, ball_x};
    on_paddle = (bx9 >= pad_lo) && (bx9 <= pad_hi);
    lives_dec = (lives_q == 2'd0) ? 2'd0 : (lives_q - 2'd1);
  end

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    x_du_d         = x_du_q;
    y_du_d         = y_du_q;
    ball_en_d      = 1'b0;
    ball_rst_n_d   = ball_rst_n_q;
    draw_req_d     = draw_req_q;
    draw_erase_d   = draw_erase_q;
    lives_d        = lives_q;
    game_over_d    = game_over_q;
    tick_overrun_d = tick_overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_SERVE: begin
        ball_rst_n_d = 1'b0;
        draw_req_d   = 1'b0;
        if (launch) begin
          ball_rst_n_d = 1'b1;
          x_du_d       = 1'b1;
          y_du_d       = 1'b1;
          draw_req_d   = 1'b1;
          draw_erase_d = 1'b0;
          state_d      = S_DRAW;
        end
      end
      S_IDLE: begin
        if (tick) begin
          draw_req_d   = 1'b1;
          draw_erase_d = 1'b1;
          state_d      = S_ERASE;
        end
      end
      S_ERASE: begin
        if (draw_req_q && draw_ack) begin
          draw_req_d = 1'b0;
          state_d    = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (ball_x == 8'd0) begin
          x_du_d = 1'b1;
        end else if (ball_x >= XMAX_C) begin
          x_du_d = 1'b0;
        end
        state_d   = S_STEP;
        ball_en_d = 1'b1;
        // one y decision per frame: top wall, then paddle, then floor, then brick
        if (ball_y == 7'd0) begin
          y_du_d = 1'b1;
        end else if (y_du_q && (ball_y == BOUNCE_Y) && on_paddle) begin
          y_du_d = 1'b0;
        end else if (y_du_q && (ball_y >= YMAX_C)) begin
          state_d   = S_LOST;
          ball_en_d = 1'b0;
        end else if (brick_hit) begin
          y_du_d = ~y_du_q;
        end
      end
      S_STEP: begin
        draw_req_d   = 1'b1;
        draw_erase_d = 1'b0;
        state_d      = S_DRAW;
      end
      S_DRAW: begin
        if (draw_req_q && draw_ack) begin
          draw_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_LOST: begin
        lives_d      = lives_dec;
        ball_rst_n_d = 1'b0;
        if (lives_dec == 2'd0) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        draw_req_d = 1'b0;
      end
      default: begin
        state_d = S_SERVE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_SERVE;
      x_du_q         <= 1'b1;
      y_du_q         <= 1'b1;
      ball_en_q      <= 1'b0;
      ball_rst_n_q   <= 1'b0;
      draw_req_q     <= 1'b0;
      draw_erase_q   <= 1'b0;
      lives_q        <= LIVES_C;
      game_over_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_du_q         <= x_du_d;
      y_du_q         <= y_du_d;
      ball_en_q      <= ball_en_d;
      ball_rst_n_q   <= ball_rst_n_d;
      draw_req_q     <= draw_req_d;
      draw_erase_q   <= draw_erase_d;
      lives_q        <= lives_d;
      game_over_q    <= game_over_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign ball_en      = ball_en_q;
  assign x_du         = x_du_q;
  assign y_du         = y_du_q;
  assign ball_rst_n   = ball_rst_n_q;
  assign draw_req     = draw_req_q;
  assign draw_erase   = draw_erase_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;
  assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - randomized scoreboard bench for ball_ctrl
module tb_ball_ctrl;

  localparam int XMAX = 159;
  localparam int YMAX = 119;
  localparam int PADDLE_Y = 112;
  localparam int PADDLE_W = 16;

  localparam int EV_DRAW = 0;
  localparam int EV_STEP = 1;
  localparam int EV_LIFE = 2;

  localparam int M_SERVE = 0;
  localparam int M_IDLE = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       launch = 1'b0;
  logic [7:0] cx = 8'd0;
  logic [6:0] cy = 7'd0;
  logic [7:0] paddle_x = 8'd0;
  logic       brick_hit = 1'b0;
  logic       draw_ack = 1'b0;
  logic       ball_en, x_du, y_du, ball_rst_n, draw_req, draw_erase;
  logic [1:0] lives;
  logic       game_over, tick_overrun;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk(clk), .resetn(resetn), .tick(tick), .launch(launch),
    .ball_x(cx), .ball_y(cy), .paddle_x(paddle_x), .brick_hit(brick_hit),
    .draw_ack(draw_ack), .ball_en(ball_en), .x_du(x_du), .y_du(y_du),
    .ball_rst_n(ball_rst_n), .draw_req(draw_req), .draw_erase(draw_erase),
    .lives(lives), .game_over(game_over), .tick_overrun(tick_overrun)
  );

  typedef struct {
    int kind;
    int v0;
    int v1;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  int  m_xd, m_yd, m_lives, m_mode;
  bit  exp_overrun;

  int  ack_delay = 0;
  int  ack_cnt = 0;
  int  stray_n = 0;
  int  stray_done = 0;
  int  tele_n = 0;
  int  tele_done = 0;
  logic [7:0] tele_x = 8'd0;
  logic [6:0] tele_y = 7'd0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic got(input int kind, input int v0, input int v1);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d v0=%0d v1=%0d expected none", kind, v0, v1);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.v0 != v0 || e.v1 != v1) begin
        errors++;
        $display("FAIL event: got kind=%0d v0=%0d v1=%0d expected kind=%0d v0=%0d v1=%0d",
                 kind, v0, v1, e.kind, e.v0, e.v1);
      end
    end
  endtask

  function automatic void push(input int kind, input int v0, input int v1);
    ev_t e;
    e.kind = kind;
    e.v0 = v0;
    e.v1 = v1;
    exp_q.push_back(e);
  endfunction

  // Position counter pair as seen by the DUT, plus a bench-side preload port
  always @(posedge clk) begin
    if (ball_rst_n !== 1'b1) begin
      cx <= 8'd0;
      cy <= 7'd0;
    end else if (ball_en === 1'b1) begin
      cx <= x_du ? cx + 8'd1 : cx - 8'd1;
      cy <= y_du ? cy + 7'd1 : cy - 7'd1;
    end else if (tele_done != tele_n) begin
      cx <= tele_x;
      cy <= tele_y;
      tele_done <= tele_n;
    end
  end

  // Plotter model: acks each request after ack_delay cycles, optional stray acks
  always @(negedge clk) begin
    if (draw_ack) begin
      draw_ack = 1'b0;
    end else if (stray_done != stray_n && !draw_req) begin
      draw_ack = 1'b1;
      stray_done++;
    end else if (draw_req) begin
      if (ack_cnt >= ack_delay) begin
        draw_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  logic ack_s = 1'b0;
  logic req_s = 1'b0;
  always @(posedge clk) begin
    ack_s <= draw_ack;
    req_s <= draw_req;
  end

  // Monitor: turns DUT activity into events and checks them against the queue
  logic       prev_req = 1'b0;
  logic [1:0] prev_lives = 2'd3;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_req = draw_req;
      prev_lives = lives;
    end else begin
      if (ack_s && req_s) chk("req_fall_after_ack", int'(draw_req), 0);
      if (draw_req && !prev_req) got(EV_DRAW, int'(draw_erase), 0);
      if (ball_en) begin
        chk("en_with_req", int'(draw_req), 0);
        got(EV_STEP, int'(x_du), int'(y_du));
      end
      if (lives != prev_lives) got(EV_LIFE, int'(lives), int'(game_over));
      prev_req = draw_req;
      prev_lives = lives;
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !draw_req) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s: got %0d pending events expected 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick = 1'b0;
    launch = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ball_en", int'(ball_en), 0);
    chk("rst_ball_rst_n", int'(ball_rst_n), 0);
    chk("rst_draw_req", int'(draw_req), 0);
    chk("rst_draw_erase", int'(draw_erase), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_x_du", int'(x_du), 1);
    chk("rst_y_du", int'(y_du), 1);
    exp_q.delete();
    resetn = 1'b1;
    m_lives = 3;
    m_mode = M_SERVE;
    m_xd = 1;
    m_yd = 1;
    exp_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic teleport(input int x, input int y);
    tele_x = 8'(x);
    tele_y = 7'(y);
    tele_n++;
    repeat (2) @(negedge clk);
  endtask

  task automatic launch_serve();
    push(EV_DRAW, 0, 0);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    wait_done("launch");
    m_xd = 1;
    m_yd = 1;
    m_mode = M_IDLE;
    chk("rst_n_after_launch", int'(ball_rst_n), 1);
  endtask

  // Tick or launch while not idle: nothing may happen except the overrun flag
  task automatic dead_stimulus();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    exp_overrun = 1'b1;
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    repeat (6) @(negedge clk);
    chk("dead_overrun", int'(tick_overrun), 1);
  endtask

  task automatic do_frame(input bit inject);
    int x, y, nxd, nyd, nl;
    bit lost;
    x = int'(cx);
    y = int'(cy);
    nxd = (x == 0) ? 1 : (x >= XMAX) ? 0 : m_xd;
    nyd = m_yd;
    lost = 1'b0;
    if (y == 0) nyd = 1;
    else if (m_yd == 1 && y == PADDLE_Y - 1 && x >= int'(paddle_x) &&
             x <= int'(paddle_x) + PADDLE_W - 1) nyd = 0;
    else if (m_yd == 1 && y >= YMAX) lost = 1'b1;
    else if (brick_hit) nyd = 1 - m_yd;
    nl = (m_lives > 0) ? m_lives - 1 : 0;
    push(EV_DRAW, 1, 0);
    if (lost) push(EV_LIFE, nl, (nl == 0) ? 1 : 0);
    else begin
      push(EV_STEP, nxd, nyd);
      push(EV_DRAW, 0, 0);
    end
    tick = 1'b1;
    @(negedge clk);
    if (inject) begin
      exp_overrun = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
    wait_done("frame");
    chk("overrun", int'(tick_overrun), int'(exp_overrun));
    if (lost) begin
      m_lives = nl;
      m_mode = (nl == 0) ? M_OVER : M_SERVE;
      chk("rst_n_after_lost", int'(ball_rst_n), 0);
      chk("lives_after_lost", int'(lives), nl);
    end else begin
      m_xd = nxd;
      m_yd = nyd;
      chk("pos_x", int'(cx), x + (nxd ? 1 : -1));
      chk("pos_y", int'(cy), y + (nyd ? 1 : -1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, p;
    do_reset();

    ack_delay = 3;
    launch_serve();

    ack_delay = 2;
    teleport(10, 10);
    do_frame(0);
    teleport(159, 50);
    do_frame(0);
    brick_hit = 1'b1;
    teleport(80, 50);
    do_frame(0);
    teleport(0, 0);
    do_frame(0);
    brick_hit = 1'b0;

    paddle_x = 8'd100;
    teleport(115, 111);
    do_frame(0);
    teleport(50, 0);
    do_frame(0);
    teleport(116, 111);
    for (int i = 0; i < 20 && m_mode == M_IDLE; i++) do_frame(0);
    chk("lives_after_miss", int'(lives), 2);

    launch_serve();
    ack_delay = 1;
    do_frame(1);

    for (int k = 0; k < 2; k++) begin
      teleport(30, 119);
      do_frame(0);
      if (m_mode == M_SERVE) launch_serve();
    end
    chk("game_over", int'(game_over), 1);
    chk("lives_zero", int'(lives), 0);
    dead_stimulus();
    do_reset();

    ack_delay = 20;
    push(EV_DRAW, 0, 0);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    for (int i = 0; i < 10 && draw_req !== 1'b1; i++) @(negedge clk);
    do_reset();
    stray_n++;
    repeat (4) @(negedge clk);
    chk("late_ack_ignored", int'(draw_req), 0);
    ack_delay = 0;
    launch_serve();

    for (int it = 0; it < 150; it++) begin
      if (m_mode == M_OVER) begin
        chk("rand_game_over", int'(game_over), 1);
        dead_stimulus();
        do_reset();
        launch_serve();
        continue;
      end
      if (m_mode == M_SERVE) begin
        launch_serve();
        continue;
      end
      ack_delay = $urandom_range(0, 3);
      brick_hit = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0: x = 0;
          1: x = XMAX;
          default: x = $urandom_range(0, XMAX);
        endcase
        case ($urandom_range(0, 5))
          0: y = 0;
          1: y = PADDLE_Y - 1;
          2: y = YMAX;
          default: y = $urandom_range(0, YMAX);
        endcase
        teleport(x, y);
      end
      if ($urandom_range(0, 1) == 1) begin
        p = int'(cx) - int'($urandom_range(0, 17));
        if (p < 0) p = 0;
        paddle_x = 8'(p);
      end else begin
        paddle_x = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 7) == 0) begin
        stray_n++;
        repeat (3) @(negedge clk);
      end
      do_frame($urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
